// File: rtl/hf_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hf_array_pkg
// Description : Shared types and defaults for the array feed logic: FSM state
//               encoding, lane count and default tile geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package hf_array_pkg;

  // Drain controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Lanes per side (west and north); the array is 4x4
  localparam int LANES         = 4;
  // Default words per lane per tile
  localparam int DEPTH_DEFAULT = 8;
  // Default payload width per lane
  localparam int W_DEFAULT     = 32;

endpackage
`default_nettype wire

// File: rtl/Pos_detector.sv
`default_nettype none
// ============================================================================
// Module      : Pos_detector
// Description : Rising-edge detector. Pulses for one cycle while the input is
//               high and its registered copy is still low.
// Revision    : 1.0 - initial release
// ============================================================================
module Pos_detector (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // Registered copy of the input; cleared so a level held through reset
  // release is seen as a fresh edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign pulse = sig & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/alignment_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : alignment_fifo_drain
// Description : Read-side controller for the eight alignment FIFOs. Drains one
//               tile of DEPTH words per lane with a one-cycle skew per lane,
//               stalling every lane together on any underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alignment_fifo_drain
  import hf_array_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int N     = LANES,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           unified_read,
  input  logic [N-1:0]   w_empty,
  input  logic [N-1:0]   n_empty,
  input  logic [N*W-1:0] w_rdata,
  input  logic [N*W-1:0] n_rdata,
  output logic [N-1:0]   w_re,
  output logic [N-1:0]   n_re,
  output logic [N*W-1:0] w_dout,
  output logic [N*W-1:0] n_dout,
  output logic [N-1:0]   w_vld,
  output logic [N-1:0]   n_vld,
  output logic           busy,
  output logic           tile_done
);

  localparam int             CW       = $clog2(DEPTH + N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH + N - 2);
  localparam logic [CW:0]    WIN_LEN  = (CW+1)'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          start;
  logic [N-1:0]  req;
  logic [N-1:0]  lane_hold;
  logic          running;
  logic          stall;
  logic [N-1:0]  re;

  Pos_detector u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig    (unified_read),
    .pulse  (start)
  );

  // Per-lane window compare, underflow contribution and output gating
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [CW:0] offset;
      // One extra bit makes cnt < i wrap to a large value, so a single
      // unsigned compare covers both window bounds
      assign offset        = {1'b0, cnt} - (CW+1)'(i);
      assign req[i]        = (offset < WIN_LEN);
      assign lane_hold[i]  = req[i] & (w_empty[i] | n_empty[i]);
      assign w_dout[i*W +: W] = w_rdata[i*W +: W] & {W{w_vld[i]}};
      assign n_dout[i*W +: W] = n_rdata[i*W +: W] & {W{n_vld[i]}};
    end
  endgenerate

  assign running   = (state == RUN);
  assign stall     = running & (|lane_hold);
  assign re        = req & {N{running & ~stall}};
  assign w_re      = re;
  assign n_re      = re;
  assign busy      = (state != IDLE);
  assign tile_done = (state == FLUSH);

  // State and slot counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: edges outside IDLE are simply not looked at
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt == CNT_LAST) begin
            state_next = FLUSH;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      FLUSH: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Lane valids follow the read enables by the FIFO read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_vld <= '0;
      n_vld <= '0;
    end else begin
      w_vld <= w_re;
      n_vld <= n_re;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alignment_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_alignment_fifo_drain
// Description : Scoreboard bench for alignment_fifo_drain. Behavioural FIFOs
//               feed the lanes; expected words and tile_done cycles are queued
//               at stimulus time and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alignment_fifo_drain;

  localparam int W     = 32;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int HMAX  = 1024;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           unified_read = 1'b0;
  logic [N-1:0]   w_empty;
  logic [N-1:0]   n_empty;
  logic [N*W-1:0] w_rdata = '0;
  logic [N*W-1:0] n_rdata = '0;
  logic [N-1:0]   w_re;
  logic [N-1:0]   n_re;
  logic [N*W-1:0] w_dout;
  logic [N*W-1:0] n_dout;
  logic [N-1:0]   w_vld;
  logic [N-1:0]   n_vld;
  logic           busy;
  logic           tile_done;

  logic [N-1:0] w_qempty = '1;
  logic [N-1:0] n_qempty = '1;
  logic [N-1:0] w_force  = '0;
  logic [N-1:0] n_force  = '0;
  logic [N-1:0] w_pend   = '0;
  logic [N-1:0] n_pend   = '0;

  assign w_empty = w_qempty | w_force;
  assign n_empty = n_qempty | n_force;

  logic [W-1:0] w_fifo [N][$];
  logic [W-1:0] n_fifo [N][$];
  logic [W-1:0] w_exp  [N][$];
  logic [W-1:0] n_exp  [N][$];
  int           exp_done [$];

  logic [N-1:0] w_re_hist [HMAX];
  logic [N-1:0] n_re_hist [HMAX];
  logic [N-1:0] vld_hist  [HMAX];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  alignment_fifo_drain #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .unified_read (unified_read),
    .w_empty      (w_empty),
    .n_empty      (n_empty),
    .w_rdata      (w_rdata),
    .n_rdata      (n_rdata),
    .w_re         (w_re),
    .n_re         (n_re),
    .w_dout       (w_dout),
    .n_dout       (n_dout),
    .w_vld        (w_vld),
    .n_vld        (n_vld),
    .busy         (busy),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  // Cycle label: value of cyc between two rising edges
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: a read sampled at an edge presents its word one cycle later
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (w_pend[i]) begin
        checks++;
        if (w_fifo[i].size() == 0) begin
          errors++;
          $display("FAIL w_underflow lane %0d: read of empty FIFO at cycle %0d", i, cyc);
        end else begin
          w_rdata[i*W +: W] = w_fifo[i].pop_front();
        end
      end
      if (n_pend[i]) begin
        checks++;
        if (n_fifo[i].size() == 0) begin
          errors++;
          $display("FAIL n_underflow lane %0d: read of empty FIFO at cycle %0d", i, cyc);
        end else begin
          n_rdata[i*W +: W] = n_fifo[i].pop_front();
        end
      end
      w_qempty[i] = (w_fifo[i].size() == 0);
      n_qempty[i] = (n_fifo[i].size() == 0);
    end
  end

  // Monitor: records enables, pops the scoreboard on every valid beat and
  // on every tile_done pulse
  always @(negedge clk) begin
    w_pend = w_re;
    n_pend = n_re;
    if (cyc < HMAX) begin
      w_re_hist[cyc] = w_re;
      n_re_hist[cyc] = n_re;
      vld_hist[cyc]  = w_vld;
    end
    for (int i = 0; i < N; i++) begin
      if (w_vld[i]) begin
        if (w_exp[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL w_dout lane %0d: unexpected beat %0h, expected none", i, w_dout[i*W +: W]);
        end else begin
          check($sformatf("w_dout lane %0d", i), 64'(w_dout[i*W +: W]), 64'(w_exp[i].pop_front()));
        end
      end else begin
        check($sformatf("w_dout_zero lane %0d", i), 64'(w_dout[i*W +: W]), 64'd0);
      end
      if (n_vld[i]) begin
        if (n_exp[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL n_dout lane %0d: unexpected beat %0h, expected none", i, n_dout[i*W +: W]);
        end else begin
          check($sformatf("n_dout lane %0d", i), 64'(n_dout[i*W +: W]), 64'(n_exp[i].pop_front()));
        end
      end else begin
        check($sformatf("n_dout_zero lane %0d", i), 64'(n_dout[i*W +: W]), 64'd0);
      end
    end
    if (tile_done) begin
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL tile_done: unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        check("tile_done cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Lane-tagged words: west 0xA<lane>, north 0xB<lane>, tile tag, index
  task automatic load_all(input int tag);
    logic [W-1:0] word;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        word = 32'hA000_0000 | (W'(i) << 24) | (W'(tag) << 8) | W'(k);
        w_fifo[i].push_back(word);
        w_exp[i].push_back(word);
        word = 32'hB000_0000 | (W'(i) << 24) | (W'(tag) << 8) | W'(k);
        n_fifo[i].push_back(word);
        n_exp[i].push_back(word);
      end
    end
  endtask

  function automatic int first_w(input int lane, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (w_re_hist[c][lane] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int last_w(input int lane, input int lo, input int hi);
    for (int c = hi; c >= lo; c--) if (w_re_hist[c][lane] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int last_vld3(input int lo, input int hi);
    for (int c = hi; c >= lo; c--) if (vld_hist[c][N-1] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int count_re(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += $countones(w_re_hist[c]) + $countones(n_re_hist[c]);
    return n;
  endfunction

  function automatic logic [2*N-1:0] or_re(input int lo, input int hi);
    logic [2*N-1:0] r = '0;
    for (int c = lo; c <= hi; c++) r |= {n_re_hist[c], w_re_hist[c]};
    return r;
  endfunction

  // Directed stimulus
  initial begin
    int t0;
    int left;
    for (int c = 0; c < HMAX; c++) begin
      w_re_hist[c] = '0; n_re_hist[c] = '0; vld_hist[c] = '0;
    end

    // Reset state
    tick(); tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset tile_done", 64'(tile_done), 64'd0);
    check("reset re", 64'({w_re, n_re}), 64'd0);
    check("reset vld", 64'({w_vld, n_vld}), 64'd0);
    resetn = 1'b1;
    tick(); tick();
    check("idle busy", 64'(busy), 64'd0);

    // Basic tile
    load_all(1);
    tick();
    unified_read = 1'b1; t0 = cyc;
    exp_done.push_back(t0 + 12);
    wait_until(t0 + 16);
    check("basic re0 first", 64'(first_w(0, t0, t0 + 15)), 64'(t0 + 1));
    check("basic re0 last",  64'(last_w(0, t0, t0 + 15)),  64'(t0 + 8));
    check("basic re3 first", 64'(first_w(3, t0, t0 + 15)), 64'(t0 + 4));
    check("basic re3 last",  64'(last_w(3, t0, t0 + 15)),  64'(t0 + 11));
    check("basic vld3 last", 64'(last_vld3(t0, t0 + 15)),  64'(t0 + 12));
    check("basic reads",     64'(count_re(t0, t0 + 15)),   64'd64);
    check("basic busy end",  64'(busy), 64'd0);

    // Underflow stall on north lane 2 at cnt = 5 for three cycles
    unified_read = 1'b0;
    load_all(2);
    tick();
    unified_read = 1'b1; t0 = cyc;
    exp_done.push_back(t0 + 15);
    wait_until(t0 + 6);
    n_force[2] = 1'b1;
    wait_until(t0 + 9);
    n_force[2] = 1'b0;
    wait_until(t0 + 19);
    check("stall re frozen", 64'(or_re(t0 + 6, t0 + 8)), 64'd0);
    check("stall resume cnt5", 64'(or_re(t0 + 9, t0 + 9)), 64'hFF);
    check("stall re0 last",  64'(last_w(0, t0, t0 + 18)),  64'(t0 + 11));
    check("stall re3 first", 64'(first_w(3, t0, t0 + 18)), 64'(t0 + 4));
    check("stall re3 last",  64'(last_w(3, t0, t0 + 18)),  64'(t0 + 14));
    check("stall vld3 last", 64'(last_vld3(t0, t0 + 18)),  64'(t0 + 15));
    check("stall reads",     64'(count_re(t0, t0 + 18)),   64'd64);

    // Empty lane outside its window does not stall
    unified_read = 1'b0;
    load_all(3);
    tick();
    w_force[3] = 1'b1;
    unified_read = 1'b1; t0 = cyc;
    exp_done.push_back(t0 + 12);
    wait_until(t0 + 4);
    w_force[3] = 1'b0;
    wait_until(t0 + 16);
    check("window re0 first", 64'(first_w(0, t0, t0 + 15)), 64'(t0 + 1));
    check("window re2 first", 64'(first_w(2, t0, t0 + 15)), 64'(t0 + 3));
    check("window cnt0 re",   64'(or_re(t0 + 1, t0 + 1)),   64'h11);
    check("window vld3 last", 64'(last_vld3(t0, t0 + 15)),  64'(t0 + 12));

    // Spurious edges during RUN are discarded
    unified_read = 1'b0;
    load_all(4);
    tick();
    unified_read = 1'b1; t0 = cyc;
    exp_done.push_back(t0 + 12);
    wait_until(t0 + 3);
    unified_read = 1'b0;
    wait_until(t0 + 5);
    unified_read = 1'b1;
    wait_until(t0 + 21);
    check("spurious vld3 last", 64'(last_vld3(t0, t0 + 20)), 64'(t0 + 12));
    check("spurious reads",     64'(count_re(t0, t0 + 20)),  64'd64);
    check("spurious no 2nd",    64'(count_re(t0 + 13, t0 + 20)), 64'd0);
    check("spurious busy",      64'(busy), 64'd0);

    // A fresh edge in IDLE starts a new tile
    unified_read = 1'b0;
    load_all(5);
    tick();
    unified_read = 1'b1; t0 = cyc;
    exp_done.push_back(t0 + 12);
    wait_until(t0 + 16);
    check("restart re0 first", 64'(first_w(0, t0, t0 + 15)), 64'(t0 + 1));
    check("restart reads",     64'(count_re(t0, t0 + 15)),   64'd64);

    // Reset mid-tile at cnt = 4
    unified_read = 1'b0;
    load_all(6);
    tick();
    unified_read = 1'b1; t0 = cyc;
    wait_until(t0 + 5);
    check("pre-reset re", 64'({n_re, w_re}), 64'hFF);
    resetn = 1'b0;
    #1;
    check("rst re",   64'({n_re, w_re}), 64'd0);
    check("rst vld",  64'({n_vld, w_vld}), 64'd0);
    check("rst wdout", 64'(|w_dout), 64'd0);
    check("rst ndout", 64'(|n_dout), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    unified_read = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_fifo[i].delete(); n_fifo[i].delete();
      w_exp[i].delete();  n_exp[i].delete();
    end
    tick(); tick();
    resetn = 1'b1;
    t0 = cyc;
    wait_until(t0 + 6);
    check("post-reset busy",  64'(busy), 64'd0);
    check("post-reset reads", 64'(count_re(t0, t0 + 5)), 64'd0);

    // Nothing left owed by the DUT
    left = exp_done.size();
    for (int i = 0; i < N; i++) left += w_exp[i].size() + n_exp[i].size();
    check("scoreboard drained", 64'(left), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alignment_fifo_drain.md
# alignment_fifo_drain

Read-side controller for the eight alignment FIFOs (west 1-4, north 1-4) that the data delivery switch fills. When the switch raises `unified_read`, this block drains one tile of `DEPTH` words from every lane into the systolic array. Lane i starts reading i cycles after lane 0, which forms the diagonal wavefront the array expects. All eight lanes stall together on any underflow, so the skew is never lost.

## Interface
- `W`, 32, payload width per lane
- `N`, 4, lanes per side (west and north); fixed at 4 in this design
- `DEPTH`, 8, words read per lane per tile
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `unified_read`  in  1  level from the switch; its rising edge starts a tile
- `w_empty`  in  N  west FIFO empty flags, bit i = west lane i+1
- `n_empty`  in  N  north FIFO empty flags
- `w_rdata`  in  N*W  west FIFO read data, lane i at [i*W +: W]
- `n_rdata`  in  N*W  north FIFO read data
- `w_re`  out  N  west FIFO read enables
- `n_re`  out  N  north FIFO read enables
- `w_dout`  out  N*W  west lane data to the array, zero when not valid
- `n_dout`  out  N*W  north lane data to the array, zero when not valid
- `w_vld`  out  N  west lane data valid
- `n_vld`  out  N  north lane data valid
- `busy`  out  1  high in RUN and FLUSH
- `tile_done`  out  1  one-cycle pulse on the final valid beat

## Operation
- Start detection:
  - Rising edge = `unified_read` high and its registered copy low.
  - The edge is sampled every cycle but acts only in IDLE.
  - Edges seen in RUN or FLUSH are discarded, not queued.
  - The fall of `unified_read` mid-tile is ignored; the tile always completes.
- States:
  - IDLE: on a start edge -> RUN, `cnt` = 0.
  - RUN: `cnt` counts read slots, from 0 to DEPTH+N-2.
    - Without a stall, `cnt` increments each cycle.
    - At `cnt` = DEPTH+N-2 with no stall -> FLUSH.
  - FLUSH: exactly one cycle, then -> IDLE.
- Lane windows:
  - Lane i is requested when `cnt` >= i and `cnt` < i+DEPTH.
  - West lane i and north lane i share the same window.
- Stall:
  - A stall occurs in any RUN cycle where some requested lane (west or north) has its empty flag set.
  - During a stall, all `w_re`/`n_re` are forced to 0 and `cnt` holds.
- Read enables:
  - `w_re[i]` = `n_re[i]` = RUN and window(i) and no stall.
  - The read enables are combinational from state, `cnt` and the empty flags.
- Data path:
  - `w_vld`/`n_vld` are the read enables registered (1-cycle FIFO read latency).
  - `dout` for lane i = `rdata` for lane i ANDed with `vld[i]`.
- Counter width: `$clog2(DEPTH+N)` bits; it never wraps within a tile.
- Reset values: every output is 0 and state = IDLE. The registered copy of `unified_read` is 0, so if `unified_read` is high when reset releases, a tile starts.
- Reset mid-tile: the tile is abandoned immediately. The block returns to IDLE with all outputs 0; no `tile_done` is issued.

## Timing
- Start latency:
  - A start edge sampled at the edge ending cycle T0 puts the block in RUN at T0+1 with `cnt` = 0.
  - `w_re[0]`/`n_re[0]` go high at T0+1, if the lane is not empty.
- Lane i:
  - `re` is first high at T0+1+i (no stalls).
  - It is high for exactly DEPTH non-stalled cycles.
  - `vld` follows `re` by one cycle.
- Stall-free tile: RUN occupies T0+1 to T0+DEPTH+N-1.
- FLUSH and completion:
  - FLUSH occurs at T0+DEPTH+N.
  - `tile_done` is high only in FLUSH, coincident with the last `vld[N-1]`.
- Back-to-back tiles: the earliest next tile begins after one IDLE cycle plus a fresh rising edge.
- Each stall cycle delays all subsequent events by exactly one cycle.

## Structure
- Shared package `hf_array_pkg`:
  - state encodings IDLE/RUN/FLUSH
  - lane count N = 4
  - default DEPTH and W
- Sub-module: reuse the existing `Pos_detector` for the `unified_read` edge.
- Window compare and stall reduction are a generate loop over the N lanes.

## Test plan
- Basic tile:
  - Stimulus: DEPTH=8, all FIFOs pre-loaded with 8 words; `unified_read` rises, start edge sampled at T0.
  - Response:
    - `re[0]` high over T0+1 to T0+8, and `re[3]` high over T0+4 to T0+11.
    - `vld[3]` last high at T0+12 with `tile_done`.
    - Exactly 64 reads total.
- Underflow stall:
  - Stimulus: `n_empty[2]` held high for 3 cycles at `cnt` = 5.
  - Response:
    - All 8 `re` low for those 3 cycles and `cnt` frozen.
    - `tile_done` slips to T0+15.
    - Relative skew between lanes is unchanged.
- Lane outside window: `w_empty[3]` high while `cnt` < 3 -> no stall, lanes 0-2 read normally.
- Spurious edges:
  - Stimulus: `unified_read` toggled low then high during RUN.
  - Response: the tile is unaffected and no second tile starts. A later edge in IDLE starts a new tile.
- Reset mid-tile:
  - Stimulus: `resetn` low at `cnt` = 4.
  - Response: all `re`/`vld`/`dout`/`busy` are 0 within the same cycle, no `tile_done` pulse, IDLE after release.
- Data integrity:
  - Stimulus: lane FIFOs loaded with lane-tagged patterns (e.g. 0xW1000000+k).
  - Response: `dout` shows each word exactly once, in order, and is zero whenever `vld` is 0.
